// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if
//   Avalon-MM slave bus bundle for the SD CMD-line engine.
//   address    : register select (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (driven by the slave)
interface sd_cmd_engine_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   SD-card CMD-line engine. Software loads ARG and writes CMD; the block
//   sends the 48-bit command frame (with CRC7), generates the SD clock,
//   waits for the response start bit and captures/CRC-checks an R48 reply.
//
//   Ports
//     clk        : system clock
//     reset_n    : asynchronous active-low reset
//     bus        : Avalon-MM slave (sd_cmd_engine_if.slave)
//     sd_clk     : SD clock, free-running, half period = CLK_DIV clk cycles
//     bidir_port : SD CMD line, released (Z) unless transmitting
//     irq        : done & irq_en, registered (only with SD_CMD_ENG_IRQ_EN)
//
//   Register map
//     0 ARG     R/W  command argument (write ignored while busy)
//     1 CMD     W    [5:0] index, [7:6] resp type; reads last accepted CMD
//     2 STATUS  R    {irq_en, crc_err, timeout, done, busy}; write clears done
//     3 RESP0   R    response bits [39:8]
//     4 RESP1   R    {18'b0, rx crc[6:0], 1'b0, rx index[5:0]}
//
//   Build option: SD_CMD_ENG_IRQ_EN adds the irq port and a R/W irq_en bit.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | line released, waiting for a CMD write
//   TX      | shifting 48 frame bits out on sd_clk falling events
//   WAIT    | line released, hunting for the response start bit
//   RX      | shifting in the 47 remaining response bits
//   DONE    | one cycle: clear busy, set done
module sd_cmd_engine #(
   parameter int CLK_DIV = 63,
   parameter int NCR_MAX = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   sd_cmd_engine_if.slave    bus,
   output logic              sd_clk,
   inout  wire               bidir_port
`ifdef SD_CMD_ENG_IRQ_EN
   ,
   output logic              irq
`endif
);

   typedef enum logic [2:0] {ST_IDLE, ST_TX, ST_WAIT, ST_RX, ST_DONE} state_t;

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int NCR_W = $clog2(NCR_MAX + 1);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [NCR_W-1:0] NCR_RELOAD = NCR_W'(NCR_MAX);

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sd_clk_q, sd_clk_d;
   logic             sync1_q, sync2_q;
   logic [31:0]      arg_q, arg_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [47:0]      tx_sr_q, tx_sr_d;
   logic [46:0]      rx_sr_q, rx_sr_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [NCR_W-1:0] ncr_q, ncr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             crc_err_q, crc_err_d;
   logic             irq_en_q, irq_en_d;
   logic [31:0]      resp0_q, resp0_d;
   logic [31:0]      resp1_q, resp1_d;
   logic             oe_q, oe_d;
   logic             dout_q, dout_d;
   logic [31:0]      readdata_q, readdata_d;

   logic             wr, tc, rise_evt, fall_evt, start, resp_none;
   logic [39:0]      tx_head;
   logic [47:0]      rx_next;

   always_comb begin
      wr        = bus.chipselect & ~bus.write_n;
      tc        = (div_cnt_q == '0);
      rise_evt  = tc & ~sd_clk_q;
      fall_evt  = tc & sd_clk_q;
      start     = wr && (bus.address == 3'd1) && (state_q == ST_IDLE);
      resp_none = (cmd_q[7:6] == 2'd0) || (cmd_q[7:6] == 2'd3);
      tx_head   = {2'b01, bus.writedata[5:0], arg_q};
      // rx_sr_q already holds the start bit (0) in its MSB once RX begins
      rx_next   = {rx_sr_q, sync2_q};

      state_d   = state_q;
      div_cnt_d = tc ? DIV_RELOAD : div_cnt_q - DIV_W'(1);
      sd_clk_d  = tc ? ~sd_clk_q : sd_clk_q;
      arg_d     = arg_q;
      cmd_d     = cmd_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      bit_cnt_d = bit_cnt_q;
      ncr_d     = ncr_q;
      busy_d    = busy_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      crc_err_d = crc_err_q;
      irq_en_d  = irq_en_q;
      resp0_d   = resp0_q;
      resp1_d   = resp1_q;
      oe_d      = oe_q;
      dout_d    = dout_q;

      if (wr && (bus.address == 3'd2)) begin
         done_d = 1'b0;
`ifdef SD_CMD_ENG_IRQ_EN
         irq_en_d = bus.writedata[4];
`else
         irq_en_d = 1'b0;
`endif
      end

      unique case (state_q)
         ST_IDLE: begin
            oe_d = 1'b0;
            if (wr && (bus.address == 3'd0)) arg_d = bus.writedata;
            if (start) begin
               cmd_d     = bus.writedata[7:0];
               tx_sr_d   = {tx_head, crc7(tx_head), 1'b1};
               bit_cnt_d = 6'd48;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               crc_err_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_TX;
            end
         end
         ST_TX: begin
            if (fall_evt) begin
               if (bit_cnt_q != '0) begin
                  oe_d      = 1'b1;
                  dout_d    = tx_sr_q[47];
                  tx_sr_d   = {tx_sr_q[46:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 6'd1;
               end else begin
                  // end-bit period is over: release the line
                  oe_d   = 1'b0;
                  dout_d = 1'b0;
                  if (resp_none) begin
                     state_d = ST_DONE;
                  end else begin
                     ncr_d   = NCR_RELOAD;
                     state_d = ST_WAIT;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (rise_evt) begin
               if (!sync2_q) begin
                  rx_sr_d   = '0;
                  bit_cnt_d = 6'd47;
                  state_d   = ST_RX;
               end else if (ncr_q == NCR_W'(1)) begin
                  timeout_d = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  ncr_d = ncr_q - NCR_W'(1);
               end
            end
         end
         ST_RX: begin
            if (rise_evt) begin
               rx_sr_d   = rx_next[46:0];
               bit_cnt_d = bit_cnt_q - 6'd1;
               if (bit_cnt_q == 6'd1) begin
                  resp0_d = rx_next[39:8];
                  resp1_d = {18'b0, rx_next[7:1], 1'b0, rx_next[45:40]};
                  if ((cmd_q[7:6] == 2'd1) &&
                      ((crc7(rx_next[47:8]) != rx_next[7:1]) || !rx_next[0]))
                     crc_err_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      case (bus.address)
         3'd0:    readdata_d = arg_q;
         3'd1:    readdata_d = {24'b0, cmd_q};
         3'd2:    readdata_d = {27'b0, irq_en_q, crc_err_q, timeout_q, done_q, busy_q};
         3'd3:    readdata_d = resp0_q;
         3'd4:    readdata_d = resp1_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         div_cnt_q  <= '0;
         sd_clk_q   <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         arg_q      <= '0;
         cmd_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         bit_cnt_q  <= '0;
         ncr_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         crc_err_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         resp0_q    <= '0;
         resp1_q    <= '0;
         oe_q       <= 1'b0;
         dout_q     <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         sd_clk_q   <= sd_clk_d;
         sync1_q    <= bidir_port;
         sync2_q    <= sync1_q;
         arg_q      <= arg_d;
         cmd_q      <= cmd_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         ncr_q      <= ncr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         crc_err_q  <= crc_err_d;
         irq_en_q   <= irq_en_d;
         resp0_q    <= resp0_d;
         resp1_q    <= resp1_d;
         oe_q       <= oe_d;
         dout_q     <= dout_d;
         readdata_q <= readdata_d;
      end
   end

`ifdef SD_CMD_ENG_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= 1'b0;
      else          irq_q <= done_q & irq_en_q;
   end
   assign irq = irq_q;
`endif

   assign bus.readdata = readdata_q;
   assign sd_clk       = sd_clk_q;
   assign bidir_port   = oe_q ? dout_q : 1'bz;

endmodule
